// File: rtl/fifo_srl_pkg.sv
// Shared constants and helpers for the SRL FIFO family used by the SpMV PE interconnect.
package fifo_srl_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

    // The counter needs one extra bit so it can represent a full FIFO (count == DEPTH).
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_GRACE_PERIOD = 2;
    localparam int DEF_ADDR_WIDTH   = clog2(DEF_DEPTH);

endpackage

// File: rtl/fifo_srl_shift_storage.sv
// Resetless shift-register array with a random-access read tap; maps onto SRL primitives.
module fifo_srl_shift_storage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            mem[0] <= data;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    assign q = mem[a];

endmodule

// File: rtl/fifo_srl_almost_full_ctrl.sv
// Show-ahead SRL FIFO controller with an almost-full grace window for pipelined producers.
// Optional sticky overflow port when FIFO_OVERFLOW_FLAG_EN is defined.
module fifo_srl_almost_full_ctrl
    import fifo_srl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int GRACE_PERIOD = DEF_GRACE_PERIOD
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
`ifdef FIFO_OVERFLOW_FLAG_EN
    ,
    output logic                  overflow
`endif
);

    localparam int CNT_WIDTH = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT  = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] ALMOST    = CNT_WIDTH'(DEPTH - GRACE_PERIOD);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  count, count_next;
    logic [ADDR_WIDTH-1:0] rd_idx, rd_idx_next;
    logic                  wr_ok, rd_ok, shift_en;

    assign wr_ok    = if_write && (count != FULL_CNT);
    assign rd_ok    = if_read && if_empty_n;
    assign shift_en = wr_ok && !reset;

    // Head lives at rd_idx; a shift moves it up, a pop moves it down, both together cancel.
    always_comb begin
        count_next  = count + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(rd_ok);
        rd_idx_next = rd_idx;
        if (wr_ok && !rd_ok && count != '0)
            rd_idx_next = rd_idx + 1'b1;
        else if (rd_ok && !wr_ok && count > ONE_CNT)
            rd_idx_next = rd_idx - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            rd_idx     <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else begin
            count      <= count_next;
            rd_idx     <= rd_idx_next;
            if_empty_n <= (count_next != '0);
            if_full_n  <= (count_next < ALMOST);
        end
    end

`ifdef FIFO_OVERFLOW_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (if_write && count == FULL_CNT)
            overflow <= 1'b1;
    end
`endif

    fifo_srl_shift_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .data (if_din),
        .ce   (shift_en),
        .a    (rd_idx),
        .q    (if_dout)
    );

endmodule

// File: tb/tb_fifo_srl_almost_full_ctrl.sv
// Scoreboard bench for fifo_srl_almost_full_ctrl (DEPTH=16, GRACE_PERIOD=2).
module tb_fifo_srl_almost_full_ctrl;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int THR = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_full_n, if_empty_n;
    logic          if_write = 1'b0, if_read = 1'b0;
    logic [DW-1:0] if_din = '0;
    logic [DW-1:0] if_dout;
`ifdef FIFO_OVERFLOW_FLAG_EN
    logic          overflow;
`endif

    int total = 0;
    int bad = 0;
    int tb_cnt = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_srl_almost_full_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (4),
        .DEPTH      (DEPTH),
        .GRACE_PERIOD (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .if_full_n  (if_full_n),
        .if_write   (if_write),
        .if_din     (if_din),
        .if_empty_n (if_empty_n),
        .if_read    (if_read),
        .if_dout    (if_dout)
`ifdef FIFO_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents head data that is being consumed, check it against the queue.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (!reset && if_read && if_empty_n) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_underflow got=%h exp=<none> t=%0t", if_dout, $time);
            end else begin
                e = exp_q.pop_front();
                chk("dout_pop", if_dout, e);
            end
        end
    end

    task automatic chk_flags();
        chk("empty_n", {31'd0, if_empty_n}, {31'd0, tb_cnt != 0});
        chk("full_n",  {31'd0, if_full_n},  {31'd0, tb_cnt < THR});
    endtask

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        int wr, rd;
        wr = (w && tb_cnt != DEPTH) ? 1 : 0;
        rd = (r && tb_cnt != 0) ? 1 : 0;
        if_write = w; if_din = d; if_read = r;
        if (wr != 0) exp_q.push_back(d);
        @(posedge clk); #1;
        tb_cnt = tb_cnt + wr - rd;
        if_write = 1'b0; if_read = 1'b0;
        chk_flags();
    endtask

    initial begin
        // Reset held for two cycles, then idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tb_cnt = 0;
        chk_flags();
`ifdef FIFO_OVERFLOW_FLAG_EN
        chk("overflow_rst", {31'd0, overflow}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);                 // read while empty is ignored

        // Fill to 14, full_n drops, two grace writes still land.
        for (int i = 1; i <= 14; i++) cyc(1'b1, DW'(i), 1'b0);
        chk("full_n_at14", {31'd0, if_full_n}, 32'd0);
        cyc(1'b1, 32'd15, 1'b0);
        cyc(1'b1, 32'd16, 1'b0);
        chk("head_at16", if_dout, 32'd1);

        // Write while full is dropped.
        cyc(1'b1, 32'hDEAD, 1'b0);
        chk("head_after_drop", if_dout, 32'd1);
`ifdef FIFO_OVERFLOW_FLAG_EN
        chk("overflow_set", {31'd0, overflow}, 32'd1);
`endif
        for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
        chk("drained_empty_n", {31'd0, if_empty_n}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
`ifdef FIFO_OVERFLOW_FLAG_EN
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
`endif

        // Simultaneous read+write with one entry.
        cyc(1'b1, 32'h5, 1'b0);
        chk("head_5", if_dout, 32'h5);
        cyc(1'b1, 32'h6, 1'b1);
        chk("rw_head_6", if_dout, 32'h6);
        chk("rw_empty_n", {31'd0, if_empty_n}, 32'd1);
        for (int i = 0; i < 100; i++) cyc(1'b1, 32'h100 + DW'(i), 1'b1);
        chk("rw_head_last", if_dout, 32'h163);
        cyc(1'b0, '0, 1'b1);
        chk("rw_drained", exp_q.size(), 32'd0);

        // Read+write on empty: only the write lands.
        cyc(1'b1, 32'hA, 1'b1);
        chk("empty_rw_dout", if_dout, 32'hA);
        chk("empty_rw_empty_n", {31'd0, if_empty_n}, 32'd1);
        cyc(1'b0, '0, 1'b1);

        // Fill 10, then reset with a write pending.
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'h200 + DW'(i), 1'b0);
        chk("head_200", if_dout, 32'h200);
        reset = 1'b1; if_write = 1'b1; if_din = 32'hBEEF;
        @(posedge clk); #1;
        reset = 1'b0; if_write = 1'b0;
        exp_q.delete();
        tb_cnt = 0;
        chk_flags();
`ifdef FIFO_OVERFLOW_FLAG_EN
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);
`endif
        cyc(1'b0, '0, 1'b1);                 // reset dropped the pending write
        cyc(1'b1, 32'h77, 1'b0);
        chk("post_reset_head", if_dout, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
